vga_stream_rx: RTL and testbench

Receiver for the VGA pixel interface our top level drives. It samples HS/VS/BLANK_N/RGB on the pixel strobe, rebuilds row/col coordinates, and emits a valid-qualified pixel stream. It also measures line and frame geometry and flags timing errors. It sits on the far side of the VGA port for loopback checking, or behind the processing chain as a frame-capture front end.

---
 rtl/vga_rx_pkg.sv | 25 ++
 rtl/vga_rx_crc16.sv | 42 ++++
 rtl/vga_stream_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_stream_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_rx_pkg : shared types and constants for the VGA stream receiver     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vga_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VBLANK = 2'd1,
    LINE   = 2'd2,
    HBLANK = 2'd3
  } rx_state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int COL_W = 10;
  localparam int ROW_W = 9;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/vga_rx_crc16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_rx_crc16 : running CRC-16-CCITT, 24 bits per enabled clk, MSB first |
// | Used only when VGA_RX_CRC_EN is defined.            Rev 1.0              |
// +--------------------------------------------------------------------------+
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [23:0] data,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic [15:0] w_next;

  // Byte-wise formulation: fold each byte into the high half, then 8 shifts.
  always_comb begin
    w_next = init ? CRC_INIT : r_crc;
    for (int b = 2; b >= 0; b--) begin
      w_next = w_next ^ {data[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++) begin
        w_next = w_next[15] ? ({w_next[14:0], 1'b0} ^ CRC_POLY) : {w_next[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= w_next;
    end
  end

  assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/vga_stream_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_stream_rx : VGA receiver -> valid-qualified pixel stream + geometry |
// | checks. Optional frame CRC built when VGA_RX_CRC_EN is defined. Rev 1.0 |
// +--------------------------------------------------------------------------+
module vga_stream_rx
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hs,
  input  logic             vs,
  input  logic             blank_n,
  input  logic [7:0]       in_R,
  input  logic [7:0]       in_G,
  input  logic [7:0]       in_B,
  output logic             out_valid,
  output logic [7:0]       out_R,
  output logic [7:0]       out_G,
  output logic [7:0]       out_B,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             sof,
  output logic             eol,
  output logic             frame_done,
  output logic [COL_W-1:0] last_cols,
  output logic [ROW_W-1:0] last_rows,
  output logic             err_hlen,
  output logic             err_vlen,
  input  logic             err_clr,
  output logic [15:0]      frame_crc
);

  localparam logic [COL_W-1:0] c_h_act = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] c_v_act = ROW_W'(V_ACTIVE);

  rx_state_t        r_state, w_state_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt, w_col_inc, w_px_col;
  logic [ROW_W-1:0] r_row, w_row_nxt, w_row_inc, w_px_row, w_lr_val;
  logic             r_vs_q, r_bl_q;
  logic             w_vs_act, w_hs_act, w_unused;
  logic             w_vs_rise, w_bl_rise, w_bl_fall;
  logic             w_emit, w_sof, w_eol, w_fd, w_set_h, w_set_v, w_lc_ld, w_lr_ld;

  logic             r_valid, r_sof, r_eol, r_fd, r_err_h, r_err_v;
  logic [23:0]      r_rgb;
  logic [COL_W-1:0] r_ocol, r_last_cols;
  logic [ROW_W-1:0] r_orow, r_last_rows;

  // Syncs are normalised to "asserted = 1"; HS carries no information here.
  assign w_vs_act  = VS_ACTIVE_LOW ? ~vs : vs;
  assign w_hs_act  = HS_ACTIVE_LOW ? ~hs : hs;
  assign w_unused  = w_hs_act;

  assign w_vs_rise = pix_en & w_vs_act & ~r_vs_q;
  assign w_bl_rise = pix_en & blank_n & ~r_bl_q;
  assign w_bl_fall = pix_en & ~blank_n & r_bl_q;

  // Counters saturate at all-ones so over-length geometry stays measurable.
  assign w_col_inc = (&r_col) ? r_col : r_col + COL_W'(1);
  assign w_row_inc = (&r_row) ? r_row : r_row + ROW_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
      r_col   <= '0;
      r_row   <= '0;
      r_vs_q  <= 1'b0;
      r_bl_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      if (pix_en) begin
        r_vs_q <= w_vs_act;
        r_bl_q <= blank_n;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_px_col    = r_col;
    w_px_row    = r_row;
    w_lr_val    = r_row;
    w_emit      = 1'b0;
    w_sof       = 1'b0;
    w_eol       = 1'b0;
    w_fd        = 1'b0;
    w_set_h     = 1'b0;
    w_set_v     = 1'b0;
    w_lc_ld     = 1'b0;
    w_lr_ld     = 1'b0;
    if (pix_en) begin
      case (r_state)
        HUNT: begin
          if (w_vs_rise) w_state_nxt = VBLANK;
        end
        VBLANK: begin
          if (w_bl_rise) begin
            w_state_nxt = LINE;
            w_px_col    = '0;
            w_px_row    = '0;
            w_emit      = 1'b1;
            w_sof       = 1'b1;
            w_col_nxt   = COL_W'(1);
            w_row_nxt   = '0;
          end
        end
        LINE: begin
          if (w_vs_rise) begin
            // Sync mid-line: the partial line counts toward the frame height.
            w_state_nxt = VBLANK;
            w_eol       = 1'b1;
            w_fd        = 1'b1;
            w_set_h     = 1'b1;
            w_lc_ld     = 1'b1;
            w_lr_ld     = 1'b1;
            w_lr_val    = w_row_inc;
            w_set_v     = (w_row_inc != c_v_act);
          end else if (w_bl_fall) begin
            w_state_nxt = HBLANK;
            w_eol       = 1'b1;
            w_lc_ld     = 1'b1;
            w_set_h     = (r_col != c_h_act);
            w_row_nxt   = w_row_inc;
          end else if (blank_n) begin
            w_emit    = (r_col < c_h_act) && (r_row < c_v_act);
            w_col_nxt = w_col_inc;
          end
        end
        HBLANK: begin
          if (w_vs_rise) begin
            w_state_nxt = VBLANK;
            w_fd        = 1'b1;
            w_lr_ld     = 1'b1;
            w_set_v     = (r_row != c_v_act);
          end else if (w_bl_rise) begin
            w_state_nxt = LINE;
            w_px_col    = '0;
            w_emit      = (r_row < c_v_act);
            w_col_nxt   = COL_W'(1);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_fd        <= 1'b0;
      r_rgb       <= '0;
      r_ocol      <= '0;
      r_orow      <= '0;
      r_last_cols <= '0;
      r_last_rows <= '0;
      r_err_h     <= 1'b0;
      r_err_v     <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_sof   <= w_sof;
      r_eol   <= w_eol;
      r_fd    <= w_fd;
      if (w_emit) begin
        r_rgb  <= {in_R, in_G, in_B};
        r_ocol <= w_px_col;
        r_orow <= w_px_row;
      end
      if (w_lc_ld) r_last_cols <= r_col;
      if (w_lr_ld) r_last_rows <= w_lr_val;
      // A fresh error beats a simultaneous clear.
      r_err_h <= w_set_h | (r_err_h & ~err_clr);
      r_err_v <= w_set_v | (r_err_v & ~err_clr);
    end
  end

  assign out_valid  = r_valid;
  assign sof        = r_sof;
  assign eol        = r_eol;
  assign frame_done = r_fd;
  assign out_R      = r_rgb[23:16];
  assign out_G      = r_rgb[15:8];
  assign out_B      = r_rgb[7:0];
  assign out_col    = r_ocol;
  assign out_row    = r_orow;
  assign last_cols  = r_last_cols;
  assign last_rows  = r_last_rows;
  assign err_hlen   = r_err_h;
  assign err_vlen   = r_err_v;

`ifdef VGA_RX_CRC_EN
  logic [15:0] w_crc_run;
  logic [15:0] r_frame_crc;

  vga_rx_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (r_sof),
    .en    (r_valid),
    .data  (r_rgb),
    .crc   (w_crc_run)
  );

  // Latched at the end of the frame_done cycle, once the last pixel is folded in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_crc <= '0;
    end else if (r_fd) begin
      r_frame_crc <= w_crc_run;
    end
  end

  assign frame_crc = r_frame_crc;
`else
  assign frame_crc = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_stream_rx : directed frames with random pixels vs. a frame model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_stream_rx;

  localparam int H    = 16;
  localparam int V    = 8;
  localparam int HT   = 24;
  localparam int ACT0 = 5;

  logic        clk;
  logic        reset, pix_en, hs, vs, blank_n, err_clr;
  logic [7:0]  in_R, in_G, in_B, out_R, out_G, out_B;
  logic        out_valid, sof, eol, frame_done, err_hlen, err_vlen;
  logic [9:0]  out_col, last_cols;
  logic [8:0]  out_row, last_rows;
  logic [15:0] frame_crc;

  vga_stream_rx #(
    .H_ACTIVE      (H),
    .V_ACTIVE      (V),
    .HS_ACTIVE_LOW (1'b1),
    .VS_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hs         (hs),
    .vs         (vs),
    .blank_n    (blank_n),
    .in_R       (in_R),
    .in_G       (in_G),
    .in_B       (in_B),
    .out_valid  (out_valid),
    .out_R      (out_R),
    .out_G      (out_G),
    .out_B      (out_B),
    .out_col    (out_col),
    .out_row    (out_row),
    .sof        (sof),
    .eol        (eol),
    .frame_done (frame_done),
    .last_cols  (last_cols),
    .last_rows  (last_rows),
    .err_hlen   (err_hlen),
    .err_vlen   (err_vlen),
    .err_clr    (err_clr),
    .frame_crc  (frame_crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference state
  bit          synced, frame_open;
  int          lines_ended;
  logic        e_valid, e_sof, e_eol, e_fd, e_errh, e_errv;
  logic [9:0]  e_col, e_lcols;
  logic [8:0]  e_row, e_lrows;
  logic [23:0] e_rgb;
  logic [15:0] run_crc, e_fcrc;

  function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] x;
    logic        fb;
    x = c;
    for (int i = 23; i >= 0; i--) begin
      fb = x[15] ^ d[i];
      x  = {x[14:0], 1'b0};
      if (fb) x = x ^ 16'h1021;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulses();
    chk("out_valid", out_valid, e_valid);
    chk("sof", sof, e_sof);
    chk("eol", eol, e_eol);
    chk("frame_done", frame_done, e_fd);
    chk("out_col", out_col, e_col);
    chk("out_row", out_row, e_row);
    chk("out_rgb", {out_R, out_G, out_B}, e_rgb);
  endtask

  task automatic check_state();
    chk("last_cols", last_cols, e_lcols);
    chk("last_rows", last_rows, e_lrows);
    chk("err_hlen", err_hlen, e_errh);
    chk("err_vlen", err_vlen, e_errv);
    chk("frame_crc", frame_crc, e_fcrc);
  endtask

  // One pix_en sample followed by an idle clk; called and returns at negedge.
  task automatic step(input logic h, input logic v, input logic b,
                      input logic [23:0] rgb, input logic clr);
    pix_en  = 1'b1;
    hs      = h;
    vs      = v;
    blank_n = b;
    {in_R, in_G, in_B} = rgb;
    err_clr = clr;
    @(negedge clk);
    pix_en  = 1'b0;
    err_clr = 1'b0;
    check_pulses();
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset(input int cycles);
    reset   = 1'b1;
    pix_en  = 1'b0;
    err_clr = 1'b0;
    repeat (cycles) @(negedge clk);
    synced = 0; frame_open = 0; lines_ended = 0;
    e_valid = 0; e_sof = 0; e_eol = 0; e_fd = 0; e_errh = 0; e_errv = 0;
    e_col = '0; e_row = '0; e_rgb = '0; e_lcols = '0; e_lrows = '0;
    run_crc = 16'hFFFF; e_fcrc = '0;
    check_pulses();
    check_state();
    reset = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    e_errh  = 1'b0;
    e_errv  = 1'b0;
    check_state();
  endtask

  task automatic close_frame(input int n);
    e_fd    = 1'b1;
    e_lrows = 9'(n);
    if (n != V) e_errv = 1'b1;
`ifdef VGA_RX_CRC_EN
    e_fcrc = run_crc;
`endif
  endtask

  // VS asserted on lines 1-2, active lines start at line 4, HS low at x=1..2.
  task automatic gen_frame(input int nact, input int odd_ly, input int odd_len,
                           input int abort_ly, input int abort_lx, input int reset_ly,
                           input int clr_ly, input bit zero_pix);
    for (int L = 0; L < 4 + nact + 2; L++) begin
      for (int x = 0; x < HT; x++) begin
        int          ly, len, lx;
        bit          act_line, is_act, aborting, vs_asrt, clr;
        logic [23:0] rgb;
        ly       = L - 4;
        act_line = (ly >= 0) && (ly < nact);
        len      = (ly == odd_ly) ? odd_len : H;
        lx       = x - ACT0;
        if (act_line && ly == reset_ly && x == 0) do_reset(2);
        is_act   = act_line && (x >= ACT0) && (x < ACT0 + len);
        aborting = act_line && (ly == abort_ly) && (lx == abort_lx);
        vs_asrt  = (L == 1) || (L == 2) || aborting;
        clr      = act_line && (ly == clr_ly) && (x == ACT0 + len);
        rgb      = zero_pix ? 24'h0 : 24'($urandom);
        e_valid = 0; e_sof = 0; e_eol = 0; e_fd = 0;
        if (clr) begin e_errh = 0; e_errv = 0; end
        if (L == 1 && x == 0) begin
          if (synced && frame_open) close_frame(lines_ended);
          synced = 1; frame_open = 0; lines_ended = 0;
        end else if (aborting) begin
          if (synced) begin
            e_eol = 1; e_lcols = 10'(lx); e_errh = 1;
            lines_ended++;
            close_frame(lines_ended);
            frame_open = 0;
          end
        end else if (is_act && synced) begin
          frame_open = 1;
          if (lx < H && ly < V) begin
            e_valid = 1;
            e_sof   = (lx == 0) && (ly == 0);
            e_col   = 10'(lx);
            e_row   = 9'(ly);
            e_rgb   = rgb;
            if (e_sof) run_crc = 16'hFFFF;
            run_crc = crc24(run_crc, rgb);
          end
        end else if (act_line && x == ACT0 + len && synced) begin
          e_eol   = 1;
          e_lcols = 10'(len);
          if (len != H) e_errh = 1;
          lines_ended++;
        end
        step(~(x == 1 || x == 2), ~vs_asrt, is_act, rgb, clr);
        if (aborting) begin
          e_valid = 0; e_sof = 0; e_eol = 0; e_fd = 0;
          for (int t = 0; t < HT; t++) step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
          return;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; blank_n = 1'b0; err_clr = 1'b0;
    in_R = '0; in_G = '0; in_B = '0;
    @(negedge clk);
    do_reset(3);

    // Nominal frames: the first one after reset produces no frame_done
    gen_frame(V, -1, 0, -1, 0, -1, -1, 1'b0);
    gen_frame(V, -1, 0, -1, 0, -1, -1, 1'b0);

    // Reset mid-frame, then a clean resync
    gen_frame(V, -1, 0, -1, 0, 4, -1, 1'b0);
    gen_frame(V, -1, 0, -1, 0, -1, -1, 1'b0);
    gen_frame(V, -1, 0, -1, 0, -1, -1, 1'b0);

    // Short line, then clear
    gen_frame(V, 2, H - 1, -1, 0, -1, -1, 1'b0);
    clr_pulse();

    // Short line with err_clr coincident with its eol: error must stay set
    gen_frame(V, 3, int'($urandom_range(1, H - 2)), -1, 0, -1, 3, 1'b0);
    clr_pulse();

    // Over-length line and over-tall frame
    gen_frame(V, 5, H + 2, -1, 0, -1, -1, 1'b0);
    gen_frame(V + 2, -1, 0, -1, 0, -1, -1, 1'b0);
    gen_frame(V, -1, 0, -1, 0, -1, -1, 1'b0);
    clr_pulse();

    // VS asserted mid-line
    gen_frame(V, -1, 0, 3, 5, -1, -1, 1'b0);
    clr_pulse();

    // All-zero pixels, closed by a following frame
    gen_frame(V, -1, 0, -1, 0, -1, -1, 1'b1);
    gen_frame(V, -1, 0, -1, 0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
